// File: rtl/rgb565_to_888_pkg.sv
// rtl/rgb565_to_888_pkg.sv - shared field positions and encodings for RGB565 to 0RGB888 conversion
package rgb565_to_888_pkg;

  localparam int PIX_PER_BEAT = 4;
  localparam int PIX565_W     = 16;
  localparam int PIX888_W     = 32;

  localparam int R5_MSB = 15;
  localparam int R5_LSB = 11;
  localparam int G6_MSB = 10;
  localparam int G6_LSB = 5;
  localparam int B5_MSB = 4;
  localparam int B5_LSB = 0;

  localparam int PAD_LSB = 24;
  localparam int R8_LSB  = 16;
  localparam int G8_LSB  = 8;
  localparam int B8_LSB  = 0;

  typedef enum logic {
    EXPAND_ZERO = 1'b0,
    EXPAND_REPL = 1'b1
  } expand_mode_e;

endpackage

// File: rtl/rgb565_pix_expand.sv
// rtl/rgb565_pix_expand.sv - combinational single-pixel RGB565 to 0RGB888 expansion
module rgb565_pix_expand
  import rgb565_to_888_pkg::*;
#(
  parameter int EXPAND_MODE = 1
) (
  input  logic [PIX565_W-1:0] i_pix,
  output logic [PIX888_W-1:0] o_pix
);

  logic [4:0] w_r5;
  logic [5:0] w_g6;
  logic [4:0] w_b5;
  logic [7:0] w_r8;
  logic [7:0] w_g8;
  logic [7:0] w_b8;

  assign w_r5 = i_pix[R5_MSB:R5_LSB];
  assign w_g6 = i_pix[G6_MSB:G6_LSB];
  assign w_b5 = i_pix[B5_MSB:B5_LSB];

  // Replicating the top bits into the gap maps full-scale 5/6-bit values to 0xFF.
  generate
    if (EXPAND_MODE == int'(EXPAND_REPL)) begin : g_repl
      assign w_r8 = {w_r5, w_r5[4:2]};
      assign w_g8 = {w_g6, w_g6[5:4]};
      assign w_b8 = {w_b5, w_b5[4:2]};
    end else begin : g_zero
      assign w_r8 = {w_r5, 3'b000};
      assign w_g8 = {w_g6, 2'b00};
      assign w_b8 = {w_b5, 3'b000};
    end
  endgenerate

  assign o_pix[PAD_LSB +: 8] = 8'h00;
  assign o_pix[R8_LSB  +: 8] = w_r8;
  assign o_pix[G8_LSB  +: 8] = w_g8;
  assign o_pix[B8_LSB  +: 8] = w_b8;

endmodule

// File: rtl/rgb565_to_888.sv
// rtl/rgb565_to_888.sv - 4-pixel RGB565 to 0RGB888 stream converter with skid buffer and packet beat counter
module rgb565_to_888
  import rgb565_to_888_pkg::*;
#(
  parameter int EXPAND_MODE = 1,
  parameter int CNT_W       = 16
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic                             s_tvalid,
  output logic                             s_tready,
  input  logic                             s_tlast,
  input  logic [PIX565_W*PIX_PER_BEAT-1:0] rgb565_in,
  output logic                             m_tvalid,
  input  logic                             m_tready,
  output logic                             m_tlast,
  output logic [PIX888_W*PIX_PER_BEAT-1:0] rgb888_out,
  output logic                             pkt_done,
  output logic [CNT_W-1:0]                 pkt_beats
);

  localparam int OUT_W = PIX888_W * PIX_PER_BEAT;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [OUT_W-1:0] w_exp;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_main_load;
  logic             w_skid_valid_nxt;
  logic [CNT_W-1:0] w_cnt_inc;

  logic [OUT_W-1:0] r_main_data;
  logic             r_main_last;
  logic             r_main_valid;
  logic [OUT_W-1:0] r_skid_data;
  logic             r_skid_last;
  logic             r_skid_valid;
  logic             r_s_tready;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_pkt_beats;
  logic             r_pkt_done;

  generate
    for (genvar k = 0; k < PIX_PER_BEAT; k++) begin : g_pix
      rgb565_pix_expand #(
        .EXPAND_MODE(EXPAND_MODE)
      ) u_expand (
        .i_pix(rgb565_in[k*PIX565_W +: PIX565_W]),
        .o_pix(w_exp[k*PIX888_W +: PIX888_W])
      );
    end
  endgenerate

  assign w_in_xfer   = s_tvalid & r_s_tready;
  assign w_out_xfer  = r_main_valid & m_tready;
  assign w_main_load = ~r_main_valid | m_tready;

  // Skid only fills when main is stalled; it always drains into main once main can load.
  assign w_skid_valid_nxt = w_main_load ? 1'b0 : (r_skid_valid | w_in_xfer);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_main_data  <= '0;
      r_main_last  <= 1'b0;
      r_main_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_last  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_s_tready   <= 1'b0;
    end else begin
      r_s_tready   <= ~w_skid_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      if (w_main_load) begin
        if (r_skid_valid) begin
          r_main_data  <= r_skid_data;
          r_main_last  <= r_skid_last;
          r_main_valid <= 1'b1;
        end else if (w_in_xfer) begin
          r_main_data  <= w_exp;
          r_main_last  <= s_tlast;
          r_main_valid <= 1'b1;
        end else begin
          r_main_valid <= 1'b0;
        end
      end else if (w_in_xfer) begin
        r_skid_data <= w_exp;
        r_skid_last <= s_tlast;
      end
    end
  end

  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt       <= '0;
      r_pkt_beats <= '0;
      r_pkt_done  <= 1'b0;
    end else begin
      r_pkt_done <= 1'b0;
      if (w_out_xfer) begin
        if (r_main_last) begin
          r_pkt_beats <= w_cnt_inc;
          r_pkt_done  <= 1'b1;
          r_cnt       <= '0;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

  assign s_tready   = r_s_tready;
  assign m_tvalid   = r_main_valid;
  assign m_tlast    = r_main_last;
  assign rgb888_out = r_main_data;
  assign pkt_done   = r_pkt_done;
  assign pkt_beats  = r_pkt_beats;

endmodule
